cnn_param_loader: RTL and testbench
===================================

// Module: cnn_param_loader
// PURPOSE
//  Upstream loader for the CNN top: accepts a byte stream of weights/biases over a valid/ready
//  handshake, packs each 9 bytes into one 72-bit SRAM word and issues write_en/data_w/addr_w
//  writes at consecutive addresses. When all words are written it reports done, then emits a
//  one-cycle sta pulse on request to launch inference.
// PARAMETERS
//  NUM_WORDS   64   words per full parameter load (1..1024)
//  BASE_ADDR   0    first SRAM word address written
//  ADDR_W      10   width of addr_w
// PORTS
//  clk           in   1       system clock, rising edge
//  rst_n         in   1       asynchronous reset, active low
//  load_start    in   1       pulse: begin a new parameter load
//  byte_valid_i  in   1       byte_i carries a valid byte
//  byte_i        in   8       parameter byte stream, LSB-byte first within a word
//  byte_ready_o  out  1       loader accepts byte_i this cycle
//  run_i         in   1       pulse: request inference start
//  write_en      out  1       SRAM write strobe, one cycle per word
//  data_w        out  72      packed word; byte k of word -> data_w[8k+7:8k]
//  addr_w        out  ADDR_W  SRAM word address
//  sta           out  1       one-cycle inference start pulse
//  busy          out  1       high in LOAD and WRITE
//  done          out  1       high in DONE (all NUM_WORDS written)
//  err           out  1       sticky: load restarted mid-transfer
// BEHAVIOUR
//  - One clock; reset asynchronous, active-low. All outputs registered.
//  - Reset: state=IDLE; byte_ready_o, write_en, sta, busy, done, err = 0; data_w = 0;
//    addr_w = BASE_ADDR; byte counter = 0; word counter = 0.
//  - Byte accepted iff byte_valid_i && byte_ready_o at a rising edge.
//  - FSM IDLE: byte_ready_o=0; load_start -> LOAD, word cnt=0, byte cnt=0, err cleared.
//  - LOAD: byte_ready_o=1; each accepted byte written to lane byte_cnt of data_w, byte_cnt++.
//    On acceptance of 9th byte (byte_cnt==8) -> WRITE; byte_ready_o drops the next cycle.
//  - WRITE: write_en=1 for exactly one cycle with data_w and addr_w=BASE_ADDR+word_cnt stable.
//    Next state: DONE if word_cnt==NUM_WORDS-1, else LOAD with word_cnt++, byte_cnt=0.
//  - Latency: write_en high the cycle after the 9th byte handshake; peak rate 10 cycles/word.
//  - DONE: done=1, byte_ready_o=0. run_i -> sta=1 next cycle for one cycle; stays DONE.
//    run_i outside DONE ignored (no sta). load_start in DONE -> LOAD (done drops, err cleared).
//  - load_start in LOAD or WRITE: partial word discarded, counters cleared, err set, stay/enter
//    LOAD; a pending WRITE cycle is suppressed (write_en not asserted).
//  - load_start and run_i same cycle in DONE: load_start wins, no sta.
//  - byte_valid_i with byte_ready_o=0: byte not consumed; source must hold it.
//  - Address arithmetic modulo 2^ADDR_W; BASE_ADDR+NUM_WORDS-1 wrap is legal, not flagged.
//  - Reset asserted mid-load: immediate return to reset values; no partial write issued.
// TESTING
//  1 Reset then load_start, stream bytes 0x01..0x09 back-to-back -> write_en one cycle,
//    data_w=0x090807060504030201, addr_w=BASE_ADDR, busy=1 throughout.
//  2 Full load NUM_WORDS=4 with random byte_valid_i gaps -> exactly 4 write_en pulses at
//    addr 0..3, data matches bytes in order, done=1 after last write, byte_ready_o=0.
//  3 In DONE pulse run_i -> sta=1 for exactly one cycle next cycle; run_i in IDLE -> no sta.
//  4 load_start after 5 bytes of word 2 -> err=1, no write of partial word, next write at
//    addr_w=BASE_ADDR with the new stream's first 9 bytes.
//  5 rst_n low during LOAD (after 3 bytes) -> all outputs at reset values asynchronously,
//    no write_en; subsequent clean load completes normally.
//  6 load_start and run_i same cycle in DONE -> sta stays 0, done=0, busy=1.

Source files
------------

// File: rtl/cnn_param_loader.sv
// Parameter loader: packs a 9-byte handshake stream into 72-bit SRAM words,
// writes them at consecutive addresses, then launches inference on request.
module cnn_param_loader #(
    parameter int NUM_WORDS = 64,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    input  logic              run_i,
    output logic              write_en,
    output logic [71:0]       data_w,
    output logic [ADDR_W-1:0] addr_w,
    output logic              sta,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t         state, state_nxt;
    logic [3:0]     byte_cnt, byte_cnt_nxt;
    logic [WCW-1:0] word_cnt, word_cnt_nxt;
    logic [71:0]    data_nxt;
    logic           err_nxt;
    logic           sta_nxt;
    logic           accept;

    assign accept = byte_valid_i && byte_ready_o;

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        word_cnt_nxt = word_cnt;
        data_nxt     = data_w;
        err_nxt      = err;
        sta_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt    = LOAD;
                    byte_cnt_nxt = '0;
                    word_cnt_nxt = '0;
                    err_nxt      = 1'b0;
                end
            end
            LOAD: begin
                // A restart wins over a byte accepted in the same cycle; that byte is dropped.
                if (load_start) begin
                    byte_cnt_nxt = '0;
                    word_cnt_nxt = '0;
                    err_nxt      = 1'b1;
                end else if (accept) begin
                    data_nxt[8*byte_cnt +: 8] = byte_i;
                    if (byte_cnt == 4'd8) begin
                        state_nxt = WRITE;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 4'd1;
                    end
                end
            end
            WRITE: begin
                if (load_start) begin
                    state_nxt    = LOAD;
                    byte_cnt_nxt = '0;
                    word_cnt_nxt = '0;
                    err_nxt      = 1'b1;
                end else if (word_cnt == WCW'(NUM_WORDS - 1)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt    = LOAD;
                    byte_cnt_nxt = '0;
                    word_cnt_nxt = word_cnt + 1'b1;
                end
            end
            DONE: begin
                if (load_start) begin
                    state_nxt    = LOAD;
                    byte_cnt_nxt = '0;
                    word_cnt_nxt = '0;
                    err_nxt      = 1'b0;
                end else if (run_i) begin
                    sta_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are flopped from the next-state decode so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            word_cnt     <= '0;
            data_w       <= '0;
            addr_w       <= ADDR_W'(BASE_ADDR);
            byte_ready_o <= 1'b0;
            write_en     <= 1'b0;
            sta          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            byte_cnt     <= byte_cnt_nxt;
            word_cnt     <= word_cnt_nxt;
            data_w       <= data_nxt;
            addr_w       <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt_nxt);
            byte_ready_o <= (state_nxt == LOAD);
            write_en     <= (state_nxt == WRITE);
            sta          <= sta_nxt;
            busy         <= (state_nxt == LOAD) || (state_nxt == WRITE);
            done         <= (state_nxt == DONE);
            err          <= err_nxt;
        end
    end

endmodule

// File: tb/tb_cnn_param_loader.sv
// Bench for cnn_param_loader: table of hand-computed words for a 4-word load
// plus directed sequences for restart, reset and run corner cases.
module tb_cnn_param_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        run_i;
    logic        write_en;
    logic [71:0] data_w;
    logic [9:0]  addr_w;
    logic        sta;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int sta_cnt  = 0;
    logic [9:0]  wq_addr[$];
    logic [71:0] wq_data[$];

    cnn_param_loader #(.NUM_WORDS(4), .BASE_ADDR(0), .ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
        .run_i(run_i), .write_en(write_en), .data_w(data_w), .addr_w(addr_w),
        .sta(sta), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write_en) begin
            wq_addr.push_back(addr_w);
            wq_data.push_back(data_w);
        end
        if (sta) sta_cnt++;
    end

    typedef struct {
        logic [7:0]  first;
        logic [8:0]  gaps;
        logic [71:0] exp_data;
        logic [9:0]  exp_addr;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        byte_valid_i = 1'b1;
        byte_i = b;
        for (int i = 0; i < 50; i++) begin
            acc = byte_ready_o;
            tick();
            if (acc) break;
        end
        byte_valid_i = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: byte %h never accepted", b);
        end
    endtask

    task automatic load_words();
        logic [7:0] b;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 9; k++) begin
                if (vecs[r].gaps[k]) tick();
                b = vecs[r].first + 8'(k);
                send_byte(b);
                if (r == 0) chk("busy_during_load", 72'(busy), 72'd1);
            end
            chk("write_en", 72'(write_en), 72'd1);
            chk("write_addr", 72'(addr_w), 72'(vecs[r].exp_addr));
            chk("write_data", data_w, vecs[r].exp_data);
            chk("ready_low_in_write", 72'(byte_ready_o), 72'd0);
        end
        tick();
        chk("done_after_load", 72'(done), 72'd1);
        chk("busy_after_load", 72'(busy), 72'd0);
        chk("ready_in_done", 72'(byte_ready_o), 72'd0);
        chk("write_count", 72'(wq_addr.size()), 72'd4);
        for (int r = 0; r < 4 && r < wq_addr.size(); r++) begin
            chk("logged_addr", 72'(wq_addr[r]), 72'(vecs[r].exp_addr));
            chk("logged_data", wq_data[r], vecs[r].exp_data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h01, 9'b000000000, 72'h090807060504030201, 10'd0};
        vecs[1] = '{8'h10, 9'b000100101, 72'h181716151413121110, 10'd1};
        vecs[2] = '{8'hF7, 9'b110000000, 72'hFFFEFDFCFBFAF9F8F7, 10'd2};
        vecs[3] = '{8'h5A, 9'b010101010, 72'h6261605F5E5D5C5B5A, 10'd3};

        rst_n = 1'b0; load_start = 1'b0; byte_valid_i = 1'b0; byte_i = '0; run_i = 1'b0;
        tick(); tick();
        chk("rst_ready", 72'(byte_ready_o), 72'd0);
        chk("rst_write_en", 72'(write_en), 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_done", 72'(done), 72'd0);
        chk("rst_err", 72'(err), 72'd0);
        chk("rst_sta", 72'(sta), 72'd0);
        chk("rst_data", data_w, 72'd0);
        chk("rst_addr", 72'(addr_w), 72'd0);
        rst_n = 1'b1;
        tick();

        // run_i in IDLE is ignored
        run_i = 1'b1; tick(); run_i = 1'b0; tick();
        chk("idle_run_no_sta", 72'(sta_cnt), 72'd0);

        // full 4-word load, first word back-to-back 0x01..0x09
        load_start = 1'b1; tick(); load_start = 1'b0;
        chk("busy_after_start", 72'(busy), 72'd1);
        chk("ready_after_start", 72'(byte_ready_o), 72'd1);
        load_words();

        // run_i in DONE -> one-cycle sta
        run_i = 1'b1; tick(); run_i = 1'b0;
        chk("sta_pulse", 72'(sta), 72'd1);
        tick();
        chk("sta_one_cycle", 72'(sta), 72'd0);
        chk("still_done", 72'(done), 72'd1);
        chk("sta_count", 72'(sta_cnt), 72'd1);

        // restart after 5 bytes of word 2
        wq_addr.delete(); wq_data.delete();
        load_start = 1'b1; tick(); load_start = 1'b0;
        chk("err_clear_from_done", 72'(err), 72'd0);
        for (int k = 0; k < 23; k++) send_byte(8'(k + 32));
        load_start = 1'b1; tick(); load_start = 1'b0;
        chk("err_set", 72'(err), 72'd1);
        chk("busy_restart", 72'(busy), 72'd1);
        chk("no_partial_write", 72'(wq_addr.size()), 72'd2);
        for (int k = 0; k < 9; k++) send_byte(8'hA0 + 8'(k));
        chk("restart_write_en", 72'(write_en), 72'd1);
        chk("restart_addr", 72'(addr_w), 72'd0);
        chk("restart_data", data_w, 72'hA8A7A6A5A4A3A2A1A0);
        chk("restart_err_sticky", 72'(err), 72'd1);

        // async reset after 3 bytes of the next word
        for (int k = 0; k < 3; k++) send_byte(8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 72'(byte_ready_o), 72'd0);
        chk("arst_busy", 72'(busy), 72'd0);
        chk("arst_err", 72'(err), 72'd0);
        chk("arst_data", data_w, 72'd0);
        chk("arst_addr", 72'(addr_w), 72'd0);
        wq_addr.delete(); wq_data.delete();
        tick();
        chk("arst_no_write", 72'(wq_addr.size()), 72'd0);
        rst_n = 1'b1;
        tick();
        load_start = 1'b1; tick(); load_start = 1'b0;
        load_words();

        // load_start and run_i together in DONE: load wins
        load_start = 1'b1; run_i = 1'b1; tick(); load_start = 1'b0; run_i = 1'b0;
        chk("tie_sta", 72'(sta), 72'd0);
        chk("tie_done", 72'(done), 72'd0);
        chk("tie_busy", 72'(busy), 72'd1);
        tick();
        chk("tie_sta_count", 72'(sta_cnt), 72'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
